// File: rtl/seg_scan_ctrl.sv
// Scan controller for an N-digit common-anode 7-seg display with double buffer.
// Optional leading-zero blanking: define SEG_SCAN_LZ_BLANK_EN.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [4*NUM_DIGITS-1:0]       data_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic                          ld,
  output logic [3:0]                    hex_out,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic                          dp,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_start
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] TMAX = CW'(REFRESH_DIV - 1);

  logic [CW-1:0]         tick_cnt;
  logic [CW-1:0]         tick_cnt_nxt;
  logic [IW-1:0]         idx_nxt;
  logic [DW-1:0]         pending;
  logic [DW-1:0]         pending_nxt;
  logic [NUM_DIGITS-1:0] pending_dp;
  logic [NUM_DIGITS-1:0] pending_dp_nxt;
  logic                  pending_valid;
  logic                  pending_valid_nxt;
  logic [DW-1:0]         display;
  logic [DW-1:0]         display_nxt;
  logic [NUM_DIGITS-1:0] dp_display;
  logic [NUM_DIGITS-1:0] dp_display_nxt;
  logic                  tick;
  logic                  wrap;
  logic                  blank;
  logic [3:0]            hex_nxt;
  logic [NUM_DIGITS-1:0] anode_nxt;
  logic                  dp_nxt;
`ifdef SEG_SCAN_LZ_BLANK_EN
  logic [IW-1:0]         lead;
`endif

  always_comb begin
    tick              = (tick_cnt == TMAX);
    wrap              = tick && (digit_idx == LAST);
    tick_cnt_nxt      = tick ? '0 : tick_cnt + 1'b1;
    idx_nxt           = digit_idx;
    pending_nxt       = pending;
    pending_dp_nxt    = pending_dp;
    pending_valid_nxt = pending_valid;
    display_nxt       = display;
    dp_display_nxt    = dp_display;

    if (wrap) begin
      idx_nxt = '0;
    end else if (tick) begin
      idx_nxt = digit_idx + 1'b1;
    end

    // Boundary swap uses the old pending; a coincident ld refills it.
    if (wrap && pending_valid) begin
      display_nxt       = pending;
      dp_display_nxt    = pending_dp;
      pending_valid_nxt = 1'b0;
    end
    if (ld) begin
      pending_nxt       = data_in;
      pending_dp_nxt    = dp_in;
      pending_valid_nxt = 1'b1;
    end

    hex_nxt   = display_nxt[4*idx_nxt +: 4];
    anode_nxt = ~(NUM_DIGITS'(1) << idx_nxt);
    dp_nxt    = ~dp_display_nxt[idx_nxt];

`ifdef SEG_SCAN_LZ_BLANK_EN
    lead = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (display_nxt[4*i +: 4] != 4'h0) begin
        lead = IW'(i);
      end
    end
    blank = (idx_nxt > lead);
`else
    blank = 1'b0;
`endif

    if (blank) begin
      anode_nxt = '1;
      dp_nxt    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt      <= '0;
      digit_idx     <= '0;
      pending       <= '0;
      pending_dp    <= '0;
      pending_valid <= 1'b0;
      display       <= '0;
      dp_display    <= '0;
      hex_out       <= 4'h0;
      anode         <= '1;
      dp            <= 1'b1;
      frame_start   <= 1'b0;
    end else begin
      tick_cnt      <= tick_cnt_nxt;
      digit_idx     <= idx_nxt;
      pending       <= pending_nxt;
      pending_dp    <= pending_dp_nxt;
      pending_valid <= pending_valid_nxt;
      display       <= display_nxt;
      dp_display    <= dp_display_nxt;
      hex_out       <= hex_nxt;
      anode         <= anode_nxt;
      dp            <= dp_nxt;
      frame_start   <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (8 digits, 4 clocks per slot).
// Expected per-cycle outputs are queued ahead and compared on the falling edge.
module tb_seg_scan_ctrl;

  localparam int N   = 8;
  localparam int DIV = 4;
  localparam int FR  = N * DIV;
  localparam logic [31:0] RST = 32'h0000_1FF0;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic [3:0]  hex_out;
  logic [7:0]  anode;
  logic        dp;
  logic [2:0]  digit_idx;
  logic        frame_start;

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .NUM_DIGITS (N),
    .REFRESH_DIV(DIV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .ld         (ld),
    .hex_out    (hex_out),
    .anode      (anode),
    .dp         (dp),
    .digit_idx  (digit_idx),
    .frame_start(frame_start)
  );

  // Edges since reset release: edge k leaves the DUT in cycle k.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] observed();
    return {15'd0, frame_start, digit_idx, dp, anode, hex_out};
  endfunction

  function automatic logic [31:0] model(int c, logic [31:0] d,
                                        logic [7:0] m);
    int         idx;
    int         lead;
    logic [3:0] h;
    logic [7:0] an;
    logic       p;
    logic       fs;
    idx  = (c / DIV) % N;
    lead = 0;
    for (int i = 0; i < N; i++) begin
      if (d[4*i +: 4] != 4'h0) lead = i;
    end
    h  = d[4*idx +: 4];
    an = ~(8'd1 << idx);
    p  = ~m[idx];
    fs = (c % FR == 0);
`ifdef SEG_SCAN_LZ_BLANK_EN
    if (idx > lead) begin
      an = 8'hFF;
      p  = 1'b1;
    end
`endif
    return {15'd0, fs, 3'(idx), p, an, h};
  endfunction

  task automatic push_range(int from, int to, logic [31:0] d,
                            logic [7:0] m);
    for (int c = from; c <= to; c++) begin
      sb.push_back('{c, model(c, d, m)});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_to(int n);
    int guard = 0;
    while (cyc != n && guard < 2000) begin
      step();
      guard++;
    end
    if (cyc != n) check("wait_to", cyc, n);
  endtask

  // Drive ld so that the DUT captures on edge n.
  task automatic load(int n, logic [31:0] d, logic [7:0] m);
    wait_to(n - 1);
    data_in = d;
    dp_in   = m;
    ld      = 1'b1;
    step();
    ld      = 1'b0;
    data_in = $urandom;
    dp_in   = 8'($urandom);
  endtask

  always @(negedge clk) begin
    if (!reset && sb.size() > 0) begin
      if (sb[0].cyc == cyc) begin
        e = sb.pop_front();
        check($sformatf("scan@%0d", cyc), observed(), e.val);
      end else if (sb[0].cyc < cyc) begin
        e = sb.pop_front();
        check("missed", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d want=done", cyc);
    $fatal(1);
  end

  initial begin
    reset   = 1'b0;
    ld      = 1'b0;
    data_in = 32'h0;
    dp_in   = 8'h0;
    repeat (6) begin
      ld      = 1'($urandom_range(0, 1));
      data_in = $urandom;
      dp_in   = 8'($urandom);
      step();
    end
    ld    = 1'b0;
    reset = 1'b1;
    repeat (3) begin
      step();
      check("reset", observed(), RST);
    end
    reset = 1'b0;

    push_range(1, 31, 32'h0, 8'h00);
    push_range(32, 95, 32'h1234_5678, 8'h01);
    push_range(96, 159, 32'hAAAA_AAAA, 8'h00);
    push_range(160, 191, 32'h1111_1111, 8'h80);
    push_range(192, 255, 32'h2222_2222, 8'h0F);
    push_range(256, 308, 32'h4444_4444, 8'hF0);

    load(5, 32'h1234_5678, 8'h01);
    load(77, 32'hAAAA_AAAA, 8'h00);
    load(138, 32'h1111_1111, 8'h80);
    load(160, 32'h2222_2222, 8'h0F);
    load(230, 32'h3333_3333, 8'h00);
    load(240, 32'h4444_4444, 8'hF0);
    load(290, 32'h5555_5555, 8'hAA);

    wait_to(308);
    @(negedge clk);
    #1;
    reset = 1'b1;
    step();
    check("reset_mid", observed(), RST);
    step();
    check("reset_hold", observed(), RST);
    reset = 1'b0;

    push_range(1, 63, 32'h0, 8'h00);
    push_range(64, 95, 32'h0000_00F0, 8'hFF);
    push_range(96, 127, 32'h0, 8'h01);
    load(40, 32'h0000_00F0, 8'hFF);
    load(70, 32'h0, 8'h01);

    wait_to(127);
    @(negedge clk);
    #1;
    check("drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
